// File: rtl/stoch_vec_decode_pkg.sv
// stoch_vec_decode_pkg
//   Shared definitions for the windowed stochastic vector decoder.
//   - state_e   : decoder FSM state encodings (IDLE=0, ACCUM=1, HOLD=2)
//   - acc_width : derives the signed accumulator width from WIN_LOG2.
//     The accumulator must hold -W..+W, so it needs WIN_LOG2+2 bits.
//   No ports (package).
package stoch_vec_decode_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    function automatic int acc_width(input int win_log2);
        return win_log2 + 2;
    endfunction

endpackage

// File: rtl/stoch_vec_decode_if.sv
// stoch_vec_decode_if
//   Bundles the decoder's control, bitstream inputs and result handshake.
//   Signals:
//     start     : begin a decode window
//     y_p, y_m  : per-element positive/negative bitstreams (bit i = element i)
//     busy      : decoder is accumulating a window
//     out_valid : estimate available
//     out_ready : consumer accepts the estimate
//     est       : packed signed estimates, element i at [i*ACC_W +: ACC_W]
//     coll_cnt  : per-element y_p&y_m collision counts (only with STOCH_DECODE_COLL_EN)
//   Modports: master = producer/consumer side, slave = decoder side.
//   Optional feature macro: STOCH_DECODE_COLL_EN.
interface stoch_vec_decode_if
    import stoch_vec_decode_pkg::*;
#(
    parameter int VEC_LEN  = 3,
    parameter int WIN_LOG2 = 8
);
    localparam int ACC_W = acc_width(WIN_LOG2);

    logic                       start;
    logic [VEC_LEN-1:0]         y_p;
    logic [VEC_LEN-1:0]         y_m;
    logic                       busy;
    logic                       out_valid;
    logic                       out_ready;
    logic [VEC_LEN*ACC_W-1:0]   est;
`ifdef STOCH_DECODE_COLL_EN
    logic [VEC_LEN*(WIN_LOG2+1)-1:0] coll_cnt;

    modport master (
        output start, y_p, y_m, out_ready,
        input  busy, out_valid, est, coll_cnt
    );
    modport slave (
        input  start, y_p, y_m, out_ready,
        output busy, out_valid, est, coll_cnt
    );
`else
    modport master (
        output start, y_p, y_m, out_ready,
        input  busy, out_valid, est
    );
    modport slave (
        input  start, y_p, y_m, out_ready,
        output busy, out_valid, est
    );
`endif

endinterface

// File: rtl/stoch_decode_acc.sv
// stoch_decode_acc
//   One element's signed up/down accumulator for the stochastic decoder.
//   Ports:
//     CLK   : clock, rising edge
//     nRST  : asynchronous active-low reset (acc -> 0)
//     clr   : synchronous clear, has priority over en
//     en    : take one sample this cycle
//     inc   : positive-part bit (+1)
//     dec   : negative-part bit (-1); inc&dec together contribute 0
//     acc   : current signed accumulator value
module stoch_decode_acc #(
    parameter int ACC_W = 10
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    clr,
    input  logic                    en,
    input  logic                    inc,
    input  logic                    dec,
    output logic signed [ACC_W-1:0] acc
);
    localparam logic signed [ACC_W-1:0] ONE = {{(ACC_W-1){1'b0}}, 1'b1};

    logic signed [ACC_W-1:0] acc_q, acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            if (inc && !dec) begin
                acc_d = acc_q + ONE;
            end else if (dec && !inc) begin
                acc_d = acc_q - ONE;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/stoch_vec_decode.sv
// stoch_vec_decode
//   Windowed decoder for signed stochastic vectors in split (+/-) bitstream
//   form. For each element it accumulates (y_p - y_m) over exactly
//   W = 2^WIN_LOG2 cycles following an accepted start, then presents the
//   signed sums on est with a valid/ready handshake.
//   Ports:
//     CLK  : clock, rising edge
//     nRST : asynchronous active-low reset (aborts any window)
//     ifc  : stoch_vec_decode_if.slave (start, y_p, y_m, busy, out_valid,
//            out_ready, est and optionally coll_cnt)
//   Optional feature macro: STOCH_DECODE_COLL_EN adds per-element counts of
//   cycles with y_p&y_m both high, captured together with est.
module stoch_vec_decode
    import stoch_vec_decode_pkg::*;
#(
    parameter int VEC_LEN  = 3,
    parameter int WIN_LOG2 = 8
) (
    input  logic                   CLK,
    input  logic                   nRST,
    stoch_vec_decode_if.slave      ifc
);
    localparam int ACC_W = acc_width(WIN_LOG2);
    // Terminal count W-1 is the all-ones counter value, so no wrap is needed.
    localparam logic [WIN_LOG2-1:0] CNT_LAST = '1;

    state_e                            state_q, state_d;
    logic [WIN_LOG2-1:0]               cnt_q, cnt_d;
    // Set once the W-th sample has been taken; the following ACCUM cycle
    // captures the sums, which puts out_valid at edge W+1 after start.
    logic                              full_q, full_d;
    logic [VEC_LEN-1:0][ACC_W-1:0]     est_q, est_d;
    logic [VEC_LEN-1:0][ACC_W-1:0]     acc_all;
    logic                              acc_clr;
    logic                              acc_en;
    logic                              capture;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        full_d  = full_q;
        est_d   = est_q;
        acc_clr = 1'b0;
        acc_en  = 1'b0;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ifc.start) begin
                    acc_clr = 1'b1;
                    cnt_d   = '0;
                    full_d  = 1'b0;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (!full_q) begin
                    acc_en = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        full_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    capture = 1'b1;
                    est_d   = acc_all;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // start is only honoured together with a transfer so an
                // unread estimate is never overwritten.
                if (ifc.out_ready) begin
                    if (ifc.start) begin
                        acc_clr = 1'b1;
                        cnt_d   = '0;
                        full_d  = 1'b0;
                        state_d = ST_ACCUM;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            est_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            est_q   <= est_d;
        end
    end

    for (genvar g = 0; g < VEC_LEN; g++) begin : g_acc
        stoch_decode_acc #(
            .ACC_W (ACC_W)
        ) u_acc (
            .CLK  (CLK),
            .nRST (nRST),
            .clr  (acc_clr),
            .en   (acc_en),
            .inc  (ifc.y_p[g]),
            .dec  (ifc.y_m[g]),
            .acc  (acc_all[g])
        );
    end

    assign ifc.busy      = (state_q == ST_ACCUM);
    assign ifc.out_valid = (state_q == ST_HOLD);
    assign ifc.est       = est_q;

`ifdef STOCH_DECODE_COLL_EN
    localparam logic [WIN_LOG2:0] COLL_MAX = {1'b1, {WIN_LOG2{1'b0}}};

    logic [VEC_LEN-1:0][WIN_LOG2:0] coll_q, coll_d;
    logic [VEC_LEN-1:0][WIN_LOG2:0] coll_out_q, coll_out_d;

    always_comb begin
        coll_d     = coll_q;
        coll_out_d = coll_out_q;
        for (int i = 0; i < VEC_LEN; i++) begin
            if (acc_clr) begin
                coll_d[i] = '0;
            end else if (acc_en && ifc.y_p[i] && ifc.y_m[i] && (coll_q[i] != COLL_MAX)) begin
                coll_d[i] = coll_q[i] + 1'b1;
            end
        end
        if (capture) begin
            coll_out_d = coll_q;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            coll_q     <= '0;
            coll_out_q <= '0;
        end else begin
            coll_q     <= coll_d;
            coll_out_q <= coll_out_d;
        end
    end

    assign ifc.coll_cnt = coll_out_q;
`endif

endmodule

// File: tb/tb_stoch_vec_decode.sv
// tb_stoch_vec_decode
//   Self-checking bench for stoch_vec_decode with VEC_LEN=3, WIN_LOG2=4 (W=16).
//   Directed windows plus randomized windows, each compared against a
//   reference that simply sums y_p - y_m (and y_p&y_m collisions) per element.
module tb_stoch_vec_decode;
    localparam int VL    = 3;
    localparam int WL    = 4;
    localparam int W     = 1 << WL;
    localparam int ACC_W = WL + 2;
    localparam int CW    = WL + 1;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    stoch_vec_decode_if #(.VEC_LEN(VL), .WIN_LOG2(WL)) ifc ();

    stoch_vec_decode #(.VEC_LEN(VL), .WIN_LOG2(WL)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .ifc  (ifc)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [VL-1:0] yp [W];
    logic [VL-1:0] ym [W];
    int exp_est  [VL];
    int exp_coll [VL];

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [31:0] est_el(input int i);
        logic signed [ACC_W-1:0] v;
        v = ifc.est[i*ACC_W +: ACC_W];
        return {{(32-ACC_W){v[ACC_W-1]}}, v};
    endfunction

`ifdef STOCH_DECODE_COLL_EN
    function automatic logic signed [31:0] coll_el(input int i);
        logic [CW-1:0] v;
        v = ifc.coll_cnt[i*CW +: CW];
        return {{(32-CW){1'b0}}, v};
    endfunction
`endif

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference: per element, net count of +1/-1 samples and count of collisions.
    task automatic model();
        for (int i = 0; i < VL; i++) begin
            exp_est[i]  = 0;
            exp_coll[i] = 0;
            for (int k = 0; k < W; k++) begin
                exp_est[i] += int'(yp[k][i]) - int'(ym[k][i]);
                if (yp[k][i] && ym[k][i]) exp_coll[i]++;
            end
            if (exp_coll[i] > W) exp_coll[i] = W;
        end
    endtask

    // Pulses start (with out_ready, so it also works from HOLD), feeds the
    // W samples from yp/ym and checks latency and results.
    task automatic run_window(input string tag);
        model();
        ifc.start = 1'b1;
        ifc.out_ready = 1'b1;
        tick();
        ifc.start = 1'b0;
        ifc.out_ready = 1'b0;
        check({tag, "_busy_start"}, 32'(ifc.busy), 1);
        check({tag, "_valid_start"}, 32'(ifc.out_valid), 0);
        for (int k = 0; k < W; k++) begin
            ifc.y_p = yp[k];
            ifc.y_m = ym[k];
            tick();
        end
        check({tag, "_valid_edgeW"}, 32'(ifc.out_valid), 0);
        ifc.y_p = VL'($urandom);
        ifc.y_m = VL'($urandom);
        tick();
        check({tag, "_valid_edgeW1"}, 32'(ifc.out_valid), 1);
        check({tag, "_busy_hold"}, 32'(ifc.busy), 0);
        for (int i = 0; i < VL; i++) begin
            check($sformatf("%s_est%0d", tag, i), est_el(i), exp_est[i]);
`ifdef STOCH_DECODE_COLL_EN
            check($sformatf("%s_coll%0d", tag, i), coll_el(i), exp_coll[i]);
`endif
        end
    endtask

    task automatic fill_const(input logic [VL-1:0] p, input logic [VL-1:0] m);
        for (int k = 0; k < W; k++) begin
            yp[k] = p;
            ym[k] = m;
        end
    endtask

    task automatic drain_to_idle(input string tag);
        ifc.out_ready = 1'b1;
        ifc.start = 1'b0;
        tick();
        ifc.out_ready = 1'b0;
        check({tag, "_idle_valid"}, 32'(ifc.out_valid), 0);
        check({tag, "_idle_busy"}, 32'(ifc.busy), 0);
    endtask

    initial begin
        ifc.start = 1'b0;
        ifc.y_p = '0;
        ifc.y_m = '0;
        ifc.out_ready = 1'b0;
        nRST = 1'b1;
        #1 nRST = 1'b0;
        #2;
        check("rst_busy", 32'(ifc.busy), 0);
        check("rst_valid", 32'(ifc.out_valid), 0);
        for (int i = 0; i < VL; i++) check($sformatf("rst_est%0d", i), est_el(i), 0);
        tick();
        tick();
        nRST = 1'b1;
        tick();

        // All elements +1 every sample.
        fill_const(3'b111, 3'b000);
        run_window("allpos");
        drain_to_idle("allpos");
        check("idle_est_kept", est_el(0), 16);

        // Per-element patterns: alternating, constant negative, silent.
        for (int k = 0; k < W; k++) begin
            yp[k] = {1'b0, 1'b0, (k % 2 == 0)};
            ym[k] = 3'b010;
        end
        run_window("pattern");

        // HOLD with no reader: start and input activity must not disturb est.
        for (int c = 0; c < 5; c++) begin
            ifc.out_ready = 1'b0;
            ifc.start = (c % 2 == 0);
            ifc.y_p = VL'($urandom);
            ifc.y_m = VL'($urandom);
            tick();
            check($sformatf("hold%0d_valid", c), 32'(ifc.out_valid), 1);
            check($sformatf("hold%0d_est1", c), est_el(1), -16);
            check($sformatf("hold%0d_est0", c), est_el(0), 8);
        end
        drain_to_idle("hold");

        // Back-to-back: transfer and start in the same HOLD cycle.
        fill_const(3'b010, 3'b000);
        run_window("b2b_a");
        fill_const(3'b000, 3'b111);
        run_window("b2b_b");

        // Abort a window with reset after 7 samples.
        fill_const(3'b111, 3'b000);
        ifc.start = 1'b1;
        ifc.out_ready = 1'b1;
        tick();
        ifc.start = 1'b0;
        ifc.out_ready = 1'b0;
        ifc.y_p = 3'b111;
        for (int k = 0; k < 7; k++) tick();
        #2 nRST = 1'b0;
        #1;
        check("abort_busy", 32'(ifc.busy), 0);
        check("abort_valid", 32'(ifc.out_valid), 0);
        for (int i = 0; i < VL; i++) check($sformatf("abort_est%0d", i), est_el(i), 0);
        tick();
        nRST = 1'b1;
        tick();
        fill_const(3'b001, 3'b000);
        run_window("fresh");
        drain_to_idle("fresh");

`ifdef STOCH_DECODE_COLL_EN
        fill_const(3'b001, 3'b001);
        run_window("coll");
        drain_to_idle("coll");
`endif

        // Randomized windows, sometimes via IDLE, sometimes back-to-back.
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < W; k++) begin
                yp[k] = VL'($urandom);
                ym[k] = VL'($urandom);
            end
            run_window($sformatf("rnd%0d", r));
            if ($urandom_range(0, 1) == 1) begin
                drain_to_idle($sformatf("rnd%0d", r));
                for (int c = 0; c < int'($urandom_range(0, 3)); c++) begin
                    ifc.y_p = VL'($urandom);
                    ifc.y_m = VL'($urandom);
                    tick();
                end
                check($sformatf("rnd%0d_idle_est0", r), est_el(0), exp_est[0]);
            end
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
